// File: rtl/soc_system_nios2_reset_seq_pkg.sv
`default_nettype none
// ==========================================================================
// soc_system_nios2_reset_seq_pkg -- shared encodings for the Nios II reset sequencer
// Rev 1.0
// ==========================================================================
package soc_system_nios2_reset_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_TAKEN = 3'd1,
      ST_HOLD       = 3'd2,
      ST_RELEASE    = 3'd3,
      ST_FAULT      = 3'd4
   } state_e;

   localparam logic [1:0] C_ADDR_CTRL    = 2'd0;
   localparam logic [1:0] C_ADDR_STATUS  = 2'd1;
   localparam logic [1:0] C_ADDR_TIMEOUT = 2'd2;
   localparam logic [1:0] C_ADDR_EVENT   = 2'd3;

   localparam int C_CTRL_START = 0;
   localparam int C_CTRL_HOLD  = 1;

   localparam int C_EV_DONE    = 0;
   localparam int C_EV_TIMEOUT = 1;
   localparam int C_EV_TAKEN   = 2;

   // STATUS layout: [4] synced resettaken, [3] busy, [2:0] state code
   function automatic logic [4:0] status_word(input state_e s, input logic synced);
      return {synced, (s != ST_IDLE), s};
   endfunction

endpackage
`default_nettype wire

// File: rtl/soc_system_nios2_reset_seq_if.sv
`default_nettype none
// ==========================================================================
// soc_system_nios2_reset_seq_if -- Avalon-MM slave port plus interrupt line
// Rev 1.0
// ==========================================================================
interface soc_system_nios2_reset_seq_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata,
      input  irq
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata,
      output irq
   );

endinterface
`default_nettype wire

// File: rtl/soc_system_sync2.sv
`default_nettype none
// ==========================================================================
// soc_system_sync2 -- generic two-flop synchronizer, clears to 0 on reset
// Rev 1.0
// ==========================================================================
module soc_system_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/soc_system_nios2_reset_seq.sv
`default_nettype none
// ==========================================================================
// soc_system_nios2_reset_seq -- Nios II reset sequencer, Avalon-MM CSRs, maskable IRQ
// Rev 1.0
// ==========================================================================
module soc_system_nios2_reset_seq
   import soc_system_nios2_reset_seq_pkg::*;
#(
   parameter int                   TIMEOUT_W   = 16,
   parameter int                   HOLD_CYCLES = 16,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT_RST = 16'hFFFF
) (
   input  logic                          clk,
   input  logic                          reset_n,
   soc_system_nios2_reset_seq_if.slave   bus,
   input  logic                          resettaken,
   output logic                          cpu_resetrequest
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam int CNT_W  = (TIMEOUT_W > HOLD_W) ? TIMEOUT_W : HOLD_W;
   localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

   // FSM state
   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               to_en_q;
   logic               req_q;

   // CSR state
   logic               hold_q;
   logic               start_q;
   logic [TIMEOUT_W-1:0] timeout_q;
   logic [2:0]         event_q;
   logic [2:0]         mask_q;
   logic [31:0]        readdata_q;
   logic               synced_d_q;

   // Combinational helpers
   logic               synced;
   logic               wr;
   logic               wr_ctrl;
   logic               wr_timeout;
   logic               wr_event;
   logic               expired;
   logic               taken_rise;
   logic               done_set;
   logic               timeout_set;
   logic               fault_clear;
   logic [2:0]         event_clr;
   logic [2:0]         event_set;
   logic [2:0]         event_d;
   logic [31:0]        readdata_d;
   logic               unused_ok;

   soc_system_sync2 #(
      .WIDTH (1)
   ) u_sync_taken (
      .clk   (clk),
      .rst_n (reset_n),
      .d_i   (resettaken),
      .q_o   (synced)
   );

   assign wr         = bus.chipselect && !bus.write_n;
   assign wr_ctrl    = wr && (bus.address == C_ADDR_CTRL);
   assign wr_timeout = wr && (bus.address == C_ADDR_TIMEOUT);
   assign wr_event   = wr && (bus.address == C_ADDR_EVENT);

   // Expiry only counts when the value snapshotted at the last load was non-zero.
   assign expired     = to_en_q && (cnt_q == '0);
   assign taken_rise  = synced && !synced_d_q;
   assign done_set    = (state_q == ST_RELEASE) && !synced;
   assign timeout_set = expired && (((state_q == ST_WAIT_TAKEN) && !synced) ||
                                    ((state_q == ST_RELEASE)    &&  synced));

   assign event_clr   = wr_event ? bus.writedata[2:0] : 3'b000;
   assign fault_clear = event_clr[C_EV_TIMEOUT];

   always_comb begin
      event_set               = 3'b000;
      event_set[C_EV_DONE]    = done_set;
      event_set[C_EV_TIMEOUT] = timeout_set;
      event_set[C_EV_TAKEN]   = taken_rise;
   end

   // A bit being set in the same cycle as its W1C stays set.
   assign event_d = (event_q & ~event_clr) | event_set;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         to_en_q <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_q) begin
                  state_q <= ST_WAIT_TAKEN;
                  cnt_q   <= CNT_W'(timeout_q);
                  to_en_q <= (timeout_q != '0);
                  req_q   <= 1'b1;
               end
            end
            ST_WAIT_TAKEN: begin
               if (synced) begin
                  state_q <= ST_HOLD;
                  cnt_q   <= C_HOLD_LOAD;
               end else if (expired) begin
                  state_q <= ST_FAULT;
                  req_q   <= 1'b0;
               end else if (to_en_q) begin
                  cnt_q   <= cnt_q - C_CNT_ONE;
               end
            end
            ST_HOLD: begin
               if (cnt_q != '0) begin
                  cnt_q   <= cnt_q - C_CNT_ONE;
               end else if (!hold_q) begin
                  state_q <= ST_RELEASE;
                  cnt_q   <= CNT_W'(timeout_q);
                  to_en_q <= (timeout_q != '0);
                  req_q   <= 1'b0;
               end
            end
            ST_RELEASE: begin
               if (!synced) begin
                  state_q <= ST_IDLE;
               end else if (expired) begin
                  state_q <= ST_FAULT;
               end else if (to_en_q) begin
                  cnt_q   <= cnt_q - C_CNT_ONE;
               end
            end
            ST_FAULT: begin
               if (fault_clear) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      readdata_d = '0;
      case (bus.address)
         C_ADDR_CTRL:    readdata_d[C_CTRL_HOLD]     = hold_q;
         C_ADDR_STATUS:  readdata_d[4:0]             = status_word(state_q, synced);
         C_ADDR_TIMEOUT: readdata_d[TIMEOUT_W-1:0]   = timeout_q;
         default:        readdata_d[2:0]             = event_q;
      endcase
   end

   // START is captured only from IDLE so a request during a sequence or FAULT is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q     <= 1'b0;
         start_q    <= 1'b0;
         timeout_q  <= TIMEOUT_RST;
         event_q    <= 3'b000;
         mask_q     <= 3'b000;
         readdata_q <= '0;
         synced_d_q <= 1'b0;
      end else begin
         start_q    <= wr_ctrl && bus.writedata[C_CTRL_START] && (state_q == ST_IDLE);
         if (wr_ctrl) begin
            hold_q <= bus.writedata[C_CTRL_HOLD];
         end
         if (wr_timeout) begin
            timeout_q <= bus.writedata[TIMEOUT_W-1:0];
         end
         if (wr_event) begin
            mask_q <= bus.writedata[10:8];
         end
         event_q    <= event_d;
         readdata_q <= readdata_d;
         synced_d_q <= synced;
      end
   end

   assign bus.readdata     = readdata_q;
   assign bus.irq          = |(event_q & mask_q);
   assign cpu_resetrequest = req_q;

   assign unused_ok = &{1'b0, bus.writedata};

endmodule
`default_nettype wire

// File: doc/soc_system_nios2_reset_seq.md
# soc_system_nios2_reset_seq

Avalon-MM-controlled reset sequencer for the Nios II soft core in `soc_system`. On host command it asserts the Nios II reset request, waits for the core's `resettaken` acknowledge, and holds reset for a programmable minimum. It then releases reset and confirms `resettaken` deasserts. Completion, timeout and acknowledge events are latched in an edge-capture register with maskable IRQ, using the same register idiom as the system's PIO slaves.

## Interface
Parameters:
- `TIMEOUT_W`, 16: width of the timeout counter/register.
- `HOLD_CYCLES`, 16: minimum cycles reset stays asserted after `resettaken` is seen (≥1).
- `TIMEOUT_RST`, 16'hFFFF: reset value of the TIMEOUT register.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  Avalon-MM word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data.
- `resettaken`  in  1  Nios II reset acknowledge; asynchronous to `clk`.
- `cpu_resetrequest`  out  1  reset request to Nios II; registered.
- `irq`  out  1  level interrupt = |(EVENT & IRQ_MASK).

## Operation
- Registers:
  - addr0 CTRL: bit0 START (write-1 pulse, reads 0); bit1 HOLD (sticky, keeps core in reset).
  - addr1 STATUS (RO): [2:0] state code, bit3 busy, bit4 synced resettaken.
  - addr2 TIMEOUT: [TIMEOUT_W-1:0] cycles. 0 = no timeout.
  - addr3 EVENT / IRQ_MASK:
    - Read returns EVENT[2:0]: bit0 DONE, bit1 TIMEOUT, bit2 TAKEN_EDGE.
    - Write-1-to-clear EVENT per bit; writedata[10:8] load IRQ_MASK.
- Writes decode only when `chipselect && !write_n`.
- `resettaken` passes through a 2-flop synchronizer. TAKEN_EDGE is set on the synced rising edge (synced & ~synced_d).
- FSM (state codes 0..4):
  - IDLE(0): req=0. A START write moves to WAIT_TAKEN and loads cnt=TIMEOUT.
  - WAIT_TAKEN(1): req=1.
    - Synced resettaken=1 → HOLD, cnt=HOLD_CYCLES-1.
    - Else cnt==0 with TIMEOUT≠0 → FAULT, set TIMEOUT event.
    - Else decrement.
  - HOLD(2): req=1. Decrement to 0. At 0 with CTRL.HOLD=0 → RELEASE, cnt=TIMEOUT. With HOLD=1, stay.
  - RELEASE(3): req=0.
    - Synced resettaken=0 → IDLE, set DONE.
    - Else timeout as in WAIT_TAKEN → FAULT.
  - FAULT(4): req=0. Exits to IDLE only when a write clears EVENT bit1.
- Boundary rules:
  - START while busy (state≠0) or in FAULT is ignored.
  - resettaken and counter expiry in the same cycle: resettaken wins.
  - Event set and W1C of the same bit in the same cycle: set wins.
  - TIMEOUT writes apply at the next counter load only.
  - `reset_n` low mid-sequence: immediate return to IDLE, req=0, all registers to reset values.

## Timing
- Reset values:
  - `readdata`=0, `cpu_resetrequest`=0, `irq`=0.
  - CTRL=0, EVENT=0, IRQ_MASK=0, TIMEOUT=TIMEOUT_RST, state IDLE.
- Read latency 1: `readdata` is registered every cycle from `address`, independent of `chipselect`. Wait-state free.
- START write at edge N → state WAIT_TAKEN and `cpu_resetrequest`=1 after edge N+1.
- `resettaken` change to FSM reaction: 2 cycles synchronizer + 1 cycle transition.
- Minimum assertion from synced acknowledge to release: HOLD_CYCLES cycles.
- `irq` is combinational from registered EVENT/IRQ_MASK. No extra latency beyond the event register.

## Structure
- Package `soc_system_nios2_reset_seq_pkg`:
  - State encoding constants.
  - Register address constants (CTRL=0, STATUS=1, TIMEOUT=2, EVENT=3).
  - EVENT bit indices.
- Sub-module `soc_system_sync2`: generic 2-flop synchronizer, async active-low reset, reset value 0. Instantiated once for `resettaken`.
- The FSM, counter and CSR block stay in the top module.

## Test plan
- Nominal: TIMEOUT=100, START, `resettaken` rises 5 cycles after req, falls 3 cycles after release.
  - Expect req high ≥HOLD_CYCLES after synced ack.
  - DONE=1, TAKEN_EDGE=1, state back to 0.
- Timeout: TIMEOUT=10, `resettaken` held 0.
  - Expect FAULT 11 cycles after entering WAIT_TAKEN, req=0, EVENT=3'b010.
  - Expect `irq`=1 with IRQ_MASK=3'b010.
  - W1C 0x2 → IDLE.
- HOLD: CTRL=0x2 before START.
  - Expect req stays 1 indefinitely past HOLD_CYCLES.
  - Write CTRL=0 → RELEASE next cycle.
- Collisions:
  - START while busy → no state change.
  - Ack and expiry on the same cycle → HOLD, no TIMEOUT event.
  - W1C of DONE in the cycle DONE sets → DONE reads 1.
- Async reset asserted in HOLD → req=0, readdata=0, EVENT=0 immediately. Sequence restartable afterwards.
- TIMEOUT=0 with ack delayed 100000 cycles → no FAULT, completes with DONE.
